// File: rtl/filter_out_serializer.sv
// Output serializer behind the 7-tap FIR: buffers 16-bit results in a small FIFO
// and streams each one as two bytes (MSB first) on a valid/ready byte link.
module filter_out_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     y_valid,
    input  logic [15:0]              y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_last,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // state | meaning
    // IDLE  | output register empty, waiting for a word in the FIFO
    // HI    | presenting word[15:8]
    // LO    | presenting word[7:0], out_last high
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HI   = 2'd1;
    localparam logic [1:0] LO   = 2'd2;

    logic [1:0]    state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   word;
    logic          xfer;
    logic          pop;
    logic          push;
    logic          drop;

    assign xfer = (state != IDLE) && out_ready;
    assign pop  = (count != '0) && ((state == IDLE) || ((state == LO) && xfer));
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push = y_valid && ((count < FULL_CNT) || pop);
    assign drop = y_valid && !push;

    assign out_valid = (state != IDLE);
    assign out_last  = (state == LO);
    assign level     = count;

    always_comb begin
        out_data = 8'h00;
        if (state == HI)
            out_data = word[15:8];
        else if (state == LO)
            out_data = word[7:0];
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= y;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word     <= 16'h0000;
            state    <= IDLE;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            if (drop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;

            if (pop) begin
                word  <= mem[rd_ptr];
                state <= HI;
            end else begin
                case (state)
                    HI:      if (xfer) state <= LO;
                    LO:      if (xfer) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_filter_out_serializer.sv
// Scoreboard bench for filter_out_serializer: queue-based reference model predicts
// the byte stream, level and overflow; a negedge monitor checks every transfer.
module tb_filter_out_serializer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        y_valid = 1'b0;
    logic [15:0] y = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        overflow;
    logic        clear_ovf = 1'b0;
    logic [2:0]  level;

    int n_tests = 0;
    int n_fail = 0;

    filter_out_serializer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .rst       (rst),
        .y_valid   (y_valid),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .level     (level)
    );

    always #5 clock = ~clock;

    // reference model: words waiting, word being shown, and which byte is shown
    logic [15:0] m_fq[$];
    logic [8:0]  exp_q[$];
    int          m_st = 0;      // 0 nothing shown, 1 high byte, 2 low byte
    logic [15:0] m_w = 16'h0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fq.delete();
        exp_q.delete();
        m_st = 0;
        m_w = 16'h0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic yv, input logic [15:0] yd, input logic rdy, input logic clr);
        bit tr, pp, ps;
        tr = (m_st != 0) && rdy;
        pp = (m_fq.size() > 0) && (m_st == 0 || (m_st == 2 && tr));
        ps = yv && (m_fq.size() < DEPTH || pp);
        if (pp) begin
            m_w = m_fq.pop_front();
            m_st = 1;
        end else if (tr) begin
            m_st = (m_st == 1) ? 2 : 0;
        end
        if (ps) begin
            m_fq.push_back(yd);
            exp_q.push_back({1'b0, yd[15:8]});
            exp_q.push_back({1'b1, yd[7:0]});
        end
        if (yv && !ps)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
    endtask

    task automatic check_state();
        chk("level", 32'(level), 32'(m_fq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("out_valid", 32'(out_valid), 32'(m_st != 0));
        if (m_st != 0) begin
            chk("out_data", 32'(out_data), 32'(m_st == 1 ? m_w[15:8] : m_w[7:0]));
            chk("out_last", 32'(out_last), 32'(m_st == 2));
        end
    endtask

    // called at posedge+1; drives one cycle of inputs and checks after the edge
    task automatic cycle(input logic yv, input logic [15:0] yd, input logic rdy, input logic clr);
        y_valid = yv;
        y = yd;
        out_ready = rdy;
        clear_ovf = clr;
        @(posedge clock);
        model_step(yv, yd, rdy, clr);
        #1;
        check_state();
    endtask

    task automatic drain();
        int budget = 60;
        while ((m_fq.size() > 0 || m_st != 0) && budget > 0) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            budget--;
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain_budget", 32'(budget > 0), 32'd1);
        chk("drain_bytes_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        y_valid = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clock) begin
        logic [8:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected none at %0t", out_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("byte", 32'(out_data), 32'(e[7:0]));
                chk("byte_last", 32'(out_last), 32'(e[8]));
            end
        end
    end

    initial begin
        @(posedge clock);
        #1;
        do_reset();

        // single word with latency
        cycle(1'b1, 16'hA55A, 1'b1, 1'b0);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("lat_t2_data", 32'(out_data), 32'hA5);
        drain();

        // back-pressure
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        chk("bp_hold", 32'(out_data), 32'h12);
        drain();

        // burst into full FIFO with one drop
        for (int i = 1; i <= 6; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        chk("burst_level", 32'(level), 32'd4);
        chk("burst_ovf", 32'(overflow), 32'd1);
        drain();

        // clear overflow, then full FIFO accepting on a LO transfer
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 16'h0777, 1'b1, 1'b0);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_level", 32'(level), 32'd4);

        // drop and clear together, then clear alone
        cycle(1'b1, 16'h0888, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        drain();

        // reset while in LO with two words queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("pre_rst_last", 32'(out_last), 32'd1);
        chk("pre_rst_level", 32'(level), 32'd2);
        out_ready = 1'b0;
        do_reset();
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        drain();

        // randomized traffic
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(0, 9) < 5, 16'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_out_serializer.md
# filter_out_serializer

Downstream stage of the 7-tap FIR filter. Captures each 16-bit filter result presented on `y_valid`/`y` into a small FIFO and emits it as two bytes, MSB first, on an 8-bit valid/ready stream toward the byte-wide output link. Results that arrive while the FIFO is full are dropped and flagged with a sticky overflow bit.

## Interface
- `DEPTH`, 4: FIFO depth in 16-bit words; power of two, ≥ 2.
- `clock`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `y_valid`  in  1  filter result strobe; one word per high cycle.
- `y`  in  16  filter result, sampled when `y_valid`=1.
- `out_valid`  out  1  byte on `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte; transfer = `out_valid` & `out_ready`.
- `out_data`  out  8  current byte.
- `out_last`  out  1  high while the low (second) byte of a word is presented.
- `overflow`  out  1  sticky: a word was dropped.
- `clear_ovf`  in  1  synchronous clear of `overflow`.
- `level`  out  log2(DEPTH)+1  words held in the FIFO, excluding the word in the output register.

## Operation
- Reset (async, immediate): FIFO empty, pointers 0, state IDLE, `out_valid`=0, `out_data`=0, `out_last`=0, `overflow`=0, `level`=0.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; separate count 0..DEPTH.
- Push: `y_valid`=1 and (count < DEPTH or a pop occurs in the same cycle). Otherwise, with `y_valid`=1 and FIFO full with no pop, the word is discarded and `overflow` is set.
- `overflow`: set wins over `clear_ovf` in the same cycle; otherwise `clear_ovf`=1 clears it the next edge.
- Output register holds one 16-bit word; the state machine selects the byte:
  - IDLE: `out_valid`=0. If count > 0, pop the head word into the output register and go to HI.
  - HI: `out_valid`=1, `out_data`=word[15:8], `out_last`=0. On transfer, go to LO.
  - LO: `out_valid`=1, `out_data`=word[7:0], `out_last`=1. On transfer: if count > 0, pop the next word and go to HI (no bubble); else go to IDLE.
- With no transfer, HI/LO hold `out_data`/`out_last` stable; `out_valid` never drops before transfer.
- Simultaneous push and pop: count unchanged; the pushed word is written at the old write pointer, the popped word is read from the old read pointer.
- Push to an empty FIFO is never bypassed straight to the output register; it goes through the FIFO.
- `level` = count, registered, updated on the same edge as the push/pop.

## Timing
- Latency: `y_valid` in cycle t, FIFO and output idle → word in FIFO at edge end of t (`level`=1 in t+1) → popped at edge end of t+1 → `out_valid`=1, high byte in t+2. Low byte follows on the cycle after the high-byte transfer.
- Sustained throughput with `out_ready`=1: 1 byte/cycle, i.e. 1 word per 2 cycles; back-to-back words have no idle cycle between LO and the next HI.
- Input accepts 1 word/cycle while space remains; the FIFO absorbs bursts of up to DEPTH words beyond the word in the output register.
- `rst` asserted mid-word: the byte in flight is abandoned and all outputs take reset values asynchronously; after release, the first push behaves as from idle.

## Test plan
- Single word: `y`=16'hA55A in one cycle, `out_ready`=1 → `out_valid` rises 2 cycles later; bytes 8'hA5 (`out_last`=0) then 8'h5A (`out_last`=1); then `out_valid`=0.
- Back-pressure: push 16'h1234, hold `out_ready`=0 for 5 cycles → `out_data`=8'h12 held stable with `out_valid`=1; release → 8'h12, then 8'h34.
- Burst/full: `out_ready`=0, push 6 words 16'h0001..16'h0006 on consecutive cycles (DEPTH=4) → word 1 in output register, 2..5 in FIFO, `level`=4, word 6 dropped, `overflow`=1; drain → bytes 00,01,00,02,…,00,05 in order, `level` reaches 0.
- Full with simultaneous pop: FIFO full, `y_valid` on the same cycle as a LO transfer → word accepted, `overflow` stays 0, `level` stays 4.
- Overflow clear: `clear_ovf` and a new drop on the same cycle → `overflow` stays 1; `clear_ovf` alone next cycle → 0.
- Reset mid-operation: assert `rst` while in LO with 2 words queued → `out_valid`=0, `level`=0 immediately; after release, push 16'hBEEF → emits BE, EF only.
